// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with synchronized, debounced single-key reporting
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DWELL_ONE  = DIV_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       row_idx;
    logic [1:0]       cap_col;
    logic [DIV_W-1:0] dwell;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       col_meta;
    logic [3:0]       col_s;

    logic [3:0] col_low;
    logic       single_low;
    logic [1:0] col_idx;
    logic [3:0] cap_pattern;
    logic       cap_bit;

    // Raw columns are asynchronous to clk; only col_s is used past this point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    assign col_low    = ~col_s;
    assign single_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

    always_comb begin
        col_idx = 2'd0;
        case (col_low)
            4'b0001: col_idx = 2'd0;
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        cap_pattern          = 4'hF;
        cap_pattern[cap_col] = 1'b0;
    end

    assign cap_bit = col_s[cap_col];

    always_comb begin
        rows          = 4'hF;
        rows[row_idx] = 1'b0;
    end

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            cap_col   <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    // Columns are only trusted on the final dwell cycle of a row.
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (single_low) begin
                            cap_col <= col_idx;
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + DWELL_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s != cap_pattern) begin
                        dwell <= '0;
                        state <= ST_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_code  <= map_key(row_idx, cap_col);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= ST_PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (cap_bit) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A low glitch returns to PRESSED without re-reporting the key.
                    if (!cap_bit) begin
                        state <= ST_PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        row_idx  <= row_idx + 2'd1;
                        dwell    <= '0;
                        state    <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule
